// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word address, cache line, and line offset width.
package lc3b_types;
   localparam int LC3B_OFFSET_BITS = 4;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_cline;
endpackage

// File: rtl/evict_buffer_datapath.sv
// Single-entry victim storage (address, line, valid) and the line-address hit compare.
module evict_buffer_datapath
   import lc3b_types::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      load,
   input  logic      clear,
   input  lc3b_word  u_addr,
   input  lc3b_cline u_wdata,
   output lc3b_word  buf_addr,
   output lc3b_cline buf_data,
   output logic      valid,
   output logic      hit
);

   lc3b_word  buf_addr_q, buf_addr_d;
   lc3b_cline buf_data_q, buf_data_d;
   logic      valid_q, valid_d;

   always_comb begin
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      valid_d    = valid_q;
      if (load) begin
         buf_addr_d = u_addr;
         buf_data_d = u_wdata;
         valid_d    = 1'b1;
      end else if (clear) begin
         valid_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_addr_q <= '0;
         buf_data_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         valid_q    <= valid_d;
      end
   end

   // Hit ignores the byte offset within the line.
   assign hit = valid_q &&
                (u_addr[15:LC3B_OFFSET_BITS] == buf_addr_q[15:LC3B_OFFSET_BITS]);

   assign buf_addr = buf_addr_q;
   assign buf_data = buf_data_q;
   assign valid    = valid_q;

endmodule

// File: rtl/evict_buffer.sv
// One-entry write-back victim buffer between cache and physical memory, draining when idle.
//
// state | meaning
// IDLE  | waiting for a request; counts idle cycles while the entry is valid
// ACK   | one-cycle completion of a hit read or an accepted write
// FETCH | read miss forwarded to memory; completes with p_resp
// DRAIN | buffered line written to memory; entry invalidated on p_resp
module evict_buffer
   import lc3b_types::*;
#(
   parameter int DRAIN_DELAY = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  lc3b_word  u_addr,
   input  logic      u_read,
   input  logic      u_write,
   input  lc3b_cline u_wdata,
   output logic      u_resp,
   output lc3b_cline u_rdata,
   output lc3b_word  p_addr,
   output logic      p_read,
   output logic      p_write,
   output lc3b_cline p_wdata,
   input  logic      p_resp,
   input  lc3b_cline p_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      FETCH = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int CNT_W = (DRAIN_DELAY < 1) ? 1 : $clog2(DRAIN_DELAY + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_DELAY);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             req_read_q, req_read_d;

   logic      dp_load;
   logic      dp_clear;
   lc3b_word  buf_addr;
   lc3b_cline buf_data;
   logic      buf_valid;
   logic      buf_hit;

   evict_buffer_datapath u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dp_load),
      .clear    (dp_clear),
      .u_addr   (u_addr),
      .u_wdata  (u_wdata),
      .buf_addr (buf_addr),
      .buf_data (buf_data),
      .valid    (buf_valid),
      .hit      (buf_hit)
   );

   // Idle counter defaults to clear; it only survives idle, valid IDLE cycles.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      req_read_d = req_read_q;
      dp_load    = 1'b0;
      dp_clear   = 1'b0;
      case (state_q)
         IDLE: begin
            if (u_read) begin
               req_read_d = 1'b1;
               state_d    = buf_hit ? ACK : FETCH;
            end else if (u_write) begin
               req_read_d = 1'b0;
               if (!buf_valid || buf_hit) begin
                  dp_load = 1'b1;
                  state_d = ACK;
               end else begin
                  state_d = DRAIN;
               end
            end else if (buf_valid) begin
               if (idle_cnt_q == CNT_MAX) begin
                  state_d = DRAIN;
               end else begin
                  idle_cnt_d = idle_cnt_q + CNT_W'(1);
               end
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         FETCH: begin
            if (p_resp) begin
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (p_resp) begin
               dp_clear = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idle_cnt_q <= '0;
         req_read_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         req_read_q <= req_read_d;
      end
   end

   // Upstream inputs reach the memory side only through FETCH.
   always_comb begin
      u_resp  = 1'b0;
      u_rdata = '0;
      p_addr  = '0;
      p_read  = 1'b0;
      p_write = 1'b0;
      p_wdata = '0;
      case (state_q)
         ACK: begin
            u_resp  = 1'b1;
            u_rdata = req_read_q ? buf_data : '0;
         end
         FETCH: begin
            p_read  = 1'b1;
            p_addr  = u_addr;
            u_rdata = p_rdata;
            u_resp  = p_resp;
         end
         DRAIN: begin
            p_write = 1'b1;
            p_addr  = buf_addr;
            p_wdata = buf_data;
         end
         default: begin
         end
      endcase
   end

endmodule
